// File: rtl/wired_pkg.sv
// Shared wired types for the branch predictor update path.
package wired_pkg;

    typedef enum logic [1:0] {
        BPU_TARGET_NPC    = 2'd0,
        BPU_TARGET_CALL   = 2'd1,
        BPU_TARGET_RETURN = 2'd2,
        BPU_TARGET_IMM    = 2'd3
    } bpu_target_type_e;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      target;
        bpu_target_type_e target_type;
        logic             cond;
        logic             taken;
        logic [4:0]       history;
        logic [1:0]       lphr;
        logic             need_update;
    } bpu_upd_t;

    // Sweep write that clears one predictor index.
    function automatic bpu_upd_t bpu_init_upd(input logic [6:0] idx);
        bpu_upd_t w;
        w             = '0;
        w.pc[9:3]     = idx;
        w.need_update = 1'b1;
        w.target_type = BPU_TARGET_NPC;
        return w;
    endfunction

endpackage

// File: rtl/wired_upd_fifo.sv
// Two-in / one-out update queue; slot writes are compacted so a lone slot 1 leaves no gap.
module wired_upd_fifo
    import wired_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 wr_en,
    input  bpu_upd_t [1:0]             wr_data,
    input  logic                       rd_en,
    output bpu_upd_t                   rd_data,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int AW = $clog2(DEPTH);

    bpu_upd_t        mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr_p1;
    logic [1:0]      n_enq;

    assign wptr_p1 = wptr + AW'(1);
    assign n_enq   = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            wptr <= wptr + AW'(n_enq);
            if (rd_en) begin
                rptr <= rptr + AW'(1);
            end
            occ <= occ + (AW+1)'(n_enq) - (AW+1)'(rd_en);
        end
    end

    // Payload storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en[0]) begin
            mem[wptr] <= wr_data[0];
        end
        if (wr_en[1]) begin
            mem[wr_en[0] ? wptr_p1 : wptr] <= wr_data[1];
        end
    end

endmodule

// File: rtl/wired_bpu_upd_arb.sv
// Arbitrates predictor write port between the post-reset index sweep and queued commit updates.
//   state   | meaning
//   ST_INIT | sweeping predictor indices 0..INIT_ENTRIES-1, commit path stalled
//   ST_RUN  | forwarding queued commit updates in order
module wired_bpu_upd_arb
    import wired_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int INIT_ENTRIES = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      c_valid_i,
    input  bpu_upd_t [1:0]  c_upd_i,
    output logic            c_ready_o,
    output logic            u_valid_o,
    input  logic            u_ready_i,
    output bpu_upd_t        u_upd_o,
    output logic            u_init_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   state;
    logic [6:0]   idx;
    logic         run;
    logic [AW:0]  occ;
    logic [1:0]   wr_en;
    logic         rd_en;
    bpu_upd_t     head;

    assign run = (state == ST_RUN);

    // Readiness looks only at registered occupancy so upstream sees no combinational loop.
    assign c_ready_o = run && (occ <= (AW+1)'(DEPTH - 2));
    assign wr_en     = c_valid_i & {c_upd_i[1].need_update, c_upd_i[0].need_update} & {2{c_ready_o}};
    assign rd_en     = run && u_valid_o && u_ready_i;

    always_comb begin
        u_valid_o = 1'b1;
        u_init_o  = 1'b1;
        u_upd_o   = bpu_init_upd(idx);
        if (run) begin
            u_valid_o = (occ != '0);
            u_init_o  = 1'b0;
            u_upd_o   = head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            idx   <= '0;
        end else if (!run && u_ready_i) begin
            if (idx == 7'(INIT_ENTRIES - 1)) begin
                state <= ST_RUN;
            end
            idx <= idx + 7'd1;
        end
    end

    wired_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (c_upd_i),
        .rd_en   (rd_en),
        .rd_data (head),
        .occ     (occ)
    );

endmodule
